sys_ctrl: RTL and testbench

//  UART command-frame controller for the multi-clock system. Decodes byte frames

---
 rtl/sys_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sys_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl.sv
// UART command-frame controller: decodes RX byte frames into RF writes/reads and ALU runs, returns results on TX.
// Optional build macro SYS_CTRL_ALU_HI_BYTE_EN: when defined, the ALU result is sent as two bytes (LO then HI).
module sys_ctrl #(
  parameter int rd        = 8,
  parameter int ALU       = 8,
  parameter int UART_size = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*ALU-1:0]     ALU_OUT,
  input  logic                 out_valid,
  input  logic [rd-1:0]        rd_data,
  input  logic                 rdData_valid,
  input  logic [UART_size-1:0] rx_p_data,
  input  logic                 RX_D_VLD,
  input  logic                 busy,
  output logic                 CLK_EN,
  output logic                 ALU_EN,
  output logic [3:0]           ALU_FUN,
  output logic [3:0]           Address,
  output logic                 wr_EN,
  output logic                 rd_EN,
  output logic [rd-1:0]        Wr_data,
  output logic [UART_size-1:0] TX_P_DATA,
  output logic                 TX_D_VLD,
  output logic                 clk_div_en
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT, S_OPA, S_OPB, S_FUN,
    S_ALU_WAIT, S_TX_RD, S_TX_LO, S_GAP_IDLE
`ifdef SYS_CTRL_ALU_HI_BYTE_EN
    , S_TX_HI, S_GAP_HI
`endif
  } state_t;

  state_t               state, state_n;
  logic [2*ALU-1:0]     alu_res, alu_res_n;
  logic [rd-1:0]        rd_buf, rd_buf_n;
  logic                 clk_en_n, alu_en_n, wr_en_n, rd_en_n, tx_vld_n;
  logic [3:0]           alu_fun_n, address_n;
  logic [rd-1:0]        wr_data_n;
  logic [UART_size-1:0] tx_data_n;

  assign clk_div_en = 1'b1;

`ifndef SYS_CTRL_ALU_HI_BYTE_EN
  logic unused_alu_hi;
  assign unused_alu_hi = ^alu_res[2*ALU-1:ALU];
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_n   = state;
    alu_res_n = alu_res;
    rd_buf_n  = rd_buf;
    clk_en_n  = CLK_EN;
    alu_en_n  = ALU_EN;
    alu_fun_n = ALU_FUN;
    address_n = Address;
    wr_data_n = Wr_data;
    tx_data_n = TX_P_DATA;
    wr_en_n   = 1'b0;
    rd_en_n   = 1'b0;
    tx_vld_n  = 1'b0;
    case (state)
      S_IDLE: if (RX_D_VLD) begin
        if      (rx_p_data == UART_size'(8'hAA)) state_n = S_WR_ADDR;
        else if (rx_p_data == UART_size'(8'hBB)) state_n = S_RD_ADDR;
        else if (rx_p_data == UART_size'(8'hCC)) state_n = S_OPA;
        else if (rx_p_data == UART_size'(8'hDD)) state_n = S_FUN;
      end
      S_WR_ADDR: if (RX_D_VLD) begin
        address_n = rx_p_data[3:0];
        state_n   = S_WR_DATA;
      end
      S_WR_DATA: if (RX_D_VLD) begin
        wr_data_n = rd'(rx_p_data);
        wr_en_n   = 1'b1;
        state_n   = S_IDLE;
      end
      S_RD_ADDR: if (RX_D_VLD) begin
        address_n = rx_p_data[3:0];
        rd_en_n   = 1'b1;
        state_n   = S_RD_WAIT;
      end
      S_RD_WAIT: if (rdData_valid) begin
        rd_buf_n = rd_data;
        state_n  = S_TX_RD;
      end
      // Operands A and B land in RF locations 0 and 1 where the ALU reads them.
      S_OPA: if (RX_D_VLD) begin
        address_n = 4'd0;
        wr_data_n = rd'(rx_p_data);
        wr_en_n   = 1'b1;
        state_n   = S_OPB;
      end
      S_OPB: if (RX_D_VLD) begin
        address_n = 4'd1;
        wr_data_n = rd'(rx_p_data);
        wr_en_n   = 1'b1;
        state_n   = S_FUN;
      end
      S_FUN: if (RX_D_VLD) begin
        alu_fun_n = rx_p_data[3:0];
        alu_en_n  = 1'b1;
        clk_en_n  = 1'b1;
        state_n   = S_ALU_WAIT;
      end
      S_ALU_WAIT: if (out_valid) begin
        alu_res_n = ALU_OUT;
        alu_en_n  = 1'b0;
        clk_en_n  = 1'b0;
        state_n   = S_TX_LO;
      end
      S_TX_RD: if (!busy) begin
        tx_data_n = UART_size'(rd_buf);
        tx_vld_n  = 1'b1;
        state_n   = S_GAP_IDLE;
      end
      S_TX_LO: if (!busy) begin
        tx_data_n = UART_size'(alu_res[ALU-1:0]);
        tx_vld_n  = 1'b1;
`ifdef SYS_CTRL_ALU_HI_BYTE_EN
        state_n   = S_GAP_HI;
`else
        state_n   = S_GAP_IDLE;
`endif
      end
`ifdef SYS_CTRL_ALU_HI_BYTE_EN
      S_GAP_HI: state_n = S_TX_HI;
      S_TX_HI: if (!busy) begin
        tx_data_n = UART_size'(alu_res[2*ALU-1:ALU]);
        tx_vld_n  = 1'b1;
        state_n   = S_GAP_IDLE;
      end
`endif
      S_GAP_IDLE: state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state     <= S_IDLE;
      alu_res   <= '0;
      rd_buf    <= '0;
      CLK_EN    <= 1'b0;
      ALU_EN    <= 1'b0;
      ALU_FUN   <= '0;
      Address   <= '0;
      wr_EN     <= 1'b0;
      rd_EN     <= 1'b0;
      Wr_data   <= '0;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
    end else begin
      state     <= state_n;
      alu_res   <= alu_res_n;
      rd_buf    <= rd_buf_n;
      CLK_EN    <= clk_en_n;
      ALU_EN    <= alu_en_n;
      ALU_FUN   <= alu_fun_n;
      Address   <= address_n;
      wr_EN     <= wr_en_n;
      rd_EN     <= rd_en_n;
      Wr_data   <= wr_data_n;
      TX_P_DATA <= tx_data_n;
      TX_D_VLD  <= tx_vld_n;
    end
  end

endmodule

// File: tb/tb_sys_ctrl.sv
// Self-checking bench for sys_ctrl: directed and randomized frames checked against expected RF-write, RF-read and TX logs.
module tb_sys_ctrl;

`ifdef SYS_CTRL_ALU_HI_BYTE_EN
  localparam int N_ALU_TX = 2;
`else
  localparam int N_ALU_TX = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        out_valid = 1'b0;
  logic [7:0]  rd_data = '0;
  logic        rdData_valid = 1'b0;
  logic [7:0]  rx_p_data = '0;
  logic        RX_D_VLD = 1'b0;
  logic        busy = 1'b0;
  logic        CLK_EN, ALU_EN, wr_EN, rd_EN, TX_D_VLD, clk_div_en;
  logic [3:0]  ALU_FUN, Address;
  logic [7:0]  Wr_data, TX_P_DATA;

  sys_ctrl dut (
    .clk(clk), .rst(rst), .ALU_OUT(ALU_OUT), .out_valid(out_valid),
    .rd_data(rd_data), .rdData_valid(rdData_valid), .rx_p_data(rx_p_data),
    .RX_D_VLD(RX_D_VLD), .busy(busy), .CLK_EN(CLK_EN), .ALU_EN(ALU_EN),
    .ALU_FUN(ALU_FUN), .Address(Address), .wr_EN(wr_EN), .rd_EN(rd_EN),
    .Wr_data(Wr_data), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .clk_div_en(clk_div_en)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Observed strobe logs and the expected logs built from the frame rules.
  logic [11:0] wr_log[$], exp_wr[$];
  logic [3:0]  rd_log[$], exp_rd[$];
  logic [7:0]  tx_log[$], exp_tx[$];
  int          tx_cyc[$];

  always @(posedge clk) begin
    cyc++;
    #2;
    if (wr_EN === 1'b1) wr_log.push_back({Address, Wr_data});
    if (rd_EN === 1'b1) rd_log.push_back(Address);
    if (TX_D_VLD === 1'b1) begin
      tx_log.push_back(TX_P_DATA);
      tx_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_p_data = b;
    RX_D_VLD  = 1'b1;
    @(negedge clk);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic pulse_rd(input logic [7:0] d);
    rd_data      = d;
    rdData_valid = 1'b1;
    @(negedge clk);
    rdData_valid = 1'b0;
  endtask

  task automatic pulse_alu(input logic [15:0] r);
    ALU_OUT   = r;
    out_valid = 1'b1;
    @(negedge clk);
    out_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (tx_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    tick(3);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_CLK_EN"}, CLK_EN, 0);
    check({tag, "_ALU_EN"}, ALU_EN, 0);
    check({tag, "_ALU_FUN"}, ALU_FUN, 0);
    check({tag, "_Address"}, Address, 0);
    check({tag, "_wr_EN"}, wr_EN, 0);
    check({tag, "_rd_EN"}, rd_EN, 0);
    check({tag, "_Wr_data"}, Wr_data, 0);
    check({tag, "_TX_P_DATA"}, TX_P_DATA, 0);
    check({tag, "_TX_D_VLD"}, TX_D_VLD, 0);
    check({tag, "_clk_div_en"}, clk_div_en, 1);
  endtask

  task automatic check_logs(input string tag);
    check({tag, "_wr_count"}, wr_log.size(), exp_wr.size());
    for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++)
      check({tag, "_wr"}, wr_log[i], exp_wr[i]);
    check({tag, "_rd_count"}, rd_log.size(), exp_rd.size());
    for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++)
      check({tag, "_rd"}, rd_log[i], exp_rd[i]);
    check({tag, "_tx_count"}, tx_log.size(), exp_tx.size());
    for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++)
      check({tag, "_tx"}, tx_log[i], exp_tx[i]);
    wr_log.delete(); exp_wr.delete();
    rd_log.delete(); exp_rd.delete();
    tx_log.delete(); exp_tx.delete();
    tx_cyc.delete();
  endtask

  // Runs one full ALU command whose operands/function are already in flight; returns after TX completes.
  task automatic finish_alu(input string tag, input logic [15:0] res, input logic [3:0] fun, input logic hold_busy);
    tick(2);
    check({tag, "_ALU_EN_on"}, ALU_EN, 1);
    check({tag, "_CLK_EN_on"}, CLK_EN, 1);
    check({tag, "_ALU_FUN"}, ALU_FUN, fun);
    busy = hold_busy;
    pulse_alu(res);
    check({tag, "_ALU_EN_off"}, ALU_EN, 0);
    check({tag, "_CLK_EN_off"}, CLK_EN, 0);
    exp_tx.push_back(res[7:0]);
    if (N_ALU_TX == 2) exp_tx.push_back(res[15:8]);
    if (hold_busy) begin
      tick(4);
      check({tag, "_busy_hold"}, tx_log.size(), 0);
      busy = 1'b0;
    end
    wait_tx(N_ALU_TX, 20);
    if (tx_cyc.size() >= 2) check({tag, "_tx_gap"}, tx_cyc[1] - tx_cyc[0], 2);
    check_logs(tag);
  endtask

  initial begin
    logic [7:0]  a, d, b2;
    logic [15:0] r;
    logic        bz;

    // Reset: one edge with rst low.
    @(negedge clk);
    rst = 1'b1;
    check_reset_outputs("reset");
    wr_log.delete(); rd_log.delete(); tx_log.delete(); tx_cyc.delete();

    // Write frames: directed then random (upper address nibble is don't-care).
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    exp_wr.push_back({4'h5, 8'h3C});
    tick(2);
    check("wr0_Address", Address, 5);
    check("wr0_Wr_data", Wr_data, 8'h3C);
    check_logs("wr0");
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      send_byte(8'hAA); send_byte(a); send_byte(d);
      exp_wr.push_back({a[3:0], d});
      tick($urandom_range(1, 3));
      check("wr_hold_Wr_data", Wr_data, d);
      check_logs("wr_rand");
    end

    // Read frame: directed with busy held, plus a stray byte while waiting to transmit.
    send_byte(8'hBB); send_byte(8'h03);
    exp_rd.push_back(4'h3);
    tick(1);
    busy = 1'b1;
    pulse_rd(8'hAA);
    send_byte(8'hAA);
    tick(4);
    check("rd0_busy_hold", tx_log.size(), 0);
    check("rd0_no_vld", TX_D_VLD, 0);
    busy = 1'b0;
    exp_tx.push_back(8'hAA);
    wait_tx(1, 10);
    check("rd0_Address", Address, 3);
    check_logs("rd0");
    for (int i = 0; i < 4; i++) begin
      a  = 8'($urandom_range(0, 255));
      d  = 8'($urandom_range(0, 255));
      bz = 1'($urandom_range(0, 1));
      send_byte(8'hBB); send_byte(a);
      exp_rd.push_back(a[3:0]);
      tick($urandom_range(0, 3));
      busy = bz;
      pulse_rd(d);
      if (bz) begin
        tick(3);
        check("rd_busy_hold", tx_log.size(), 0);
        busy = 1'b0;
      end
      exp_tx.push_back(d);
      wait_tx(1, 10);
      check_logs("rd_rand");
    end

    // ALU frames: directed CC,07,02,00 with result 0x0109, then random.
    send_byte(8'hCC); send_byte(8'h07); send_byte(8'h02); send_byte(8'h00);
    exp_wr.push_back({4'h0, 8'h07});
    exp_wr.push_back({4'h1, 8'h02});
    finish_alu("alu0", 16'h0109, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      a  = 8'($urandom_range(0, 255));
      d  = 8'($urandom_range(0, 255));
      b2 = 8'($urandom_range(0, 255));
      r  = 16'($urandom_range(0, 65535));
      send_byte(8'hCC); send_byte(a); send_byte(d); send_byte(b2);
      exp_wr.push_back({4'h0, a});
      exp_wr.push_back({4'h1, d});
      finish_alu("alu_rand", r, b2[3:0], 1'($urandom_range(0, 1)));
    end

    // Function-only frame: no RF writes.
    r = 16'($urandom_range(0, 65535));
    send_byte(8'hDD); send_byte(8'hF2);
    finish_alu("fun_only", r, 4'h2, 1'b0);

    // Unknown bytes in IDLE produce no strobes.
    send_byte(8'h55);
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom_range(0, 255));
      if (a == 8'hAA || a == 8'hBB || a == 8'hCC || a == 8'hDD) a = 8'h00;
      send_byte(a);
    end
    tick(3);
    check("unknown_ALU_EN", ALU_EN, 0);
    check_logs("unknown");

    // Reset during RD_WAIT aborts the frame; the late read data is not transmitted.
    send_byte(8'hBB); send_byte(8'h09);
    exp_rd.push_back(4'h9);
    tick(1);
    do_reset();
    check_reset_outputs("rst_rdwait");
    pulse_rd(8'h5A);
    tick(4);
    check_logs("rst_rdwait");
    d = 8'($urandom_range(0, 255));
    send_byte(8'hBB); send_byte(8'h0C);
    exp_rd.push_back(4'hC);
    pulse_rd(d);
    exp_tx.push_back(d);
    wait_tx(1, 10);
    check_logs("rd_after_rst");

    // Reset mid write frame: the trailing data byte lands in IDLE and is ignored.
    send_byte(8'hAA); send_byte(8'h06);
    do_reset();
    send_byte(8'h3C);
    tick(2);
    check_logs("rst_wr");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
